// File: rtl/fifo_ctrl_pkg.sv
// Shared types for the FIFO control front end: default word width and the
// command conditioner state encoding.
package fifo_ctrl_pkg;

  localparam int DATA_W = 15;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } cmd_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for a single asynchronous level; RST_VAL sets the
// value both stages take in reset so the output idles in a known sense.
module btn_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/fifo_cmd_conditioner.sv
// Turns a raw active-low button, mode switch and data switches into one-cycle
// push/pop/reject strobes. Define FIFO_CMD_AUTOREPEAT_EN for hold-to-repeat.
module fifo_cmd_conditioner #(
  parameter int DATA_W          = fifo_ctrl_pkg::DATA_W,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              button,
  input  logic              mode,
  input  logic [DATA_W-1:0] datain,
  input  logic              full,
  input  logic              empty,
  output logic              wr_en,
  output logic              rd_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              rejected
);
  import fifo_ctrl_pkg::*;

  localparam int CNT_MAX = max2(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] SAT_C  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic btn_s, mode_s;

  btn_sync #(.RST_VAL(1'b1)) u_btn_sync (
    .clk(clk), .reset_n(reset_n), .d(button), .q(btn_s)
  );

  btn_sync #(.RST_VAL(1'b0)) u_mode_sync (
    .clk(clk), .reset_n(reset_n), .d(mode), .q(mode_s)
  );

  cmd_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == SAT_C) ? v : v + ONE_C;
  endfunction

`ifdef FIFO_CMD_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST_C = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rpt_q, rpt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rpt_q <= '0;
    else          rpt_q <= rpt_d;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
`ifdef FIFO_CMD_AUTOREPEAT_EN
    rpt_d   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = ONE_C;
        end
      end
      PRESS_WAIT: begin
        if (btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_C) begin
          // Press has been low for the full debounce window: accept it.
          state_d = HELD;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      HELD: begin
        if (btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = ONE_C;
        end
`ifdef FIFO_CMD_AUTOREPEAT_EN
        else if (rpt_q >= RPT_LAST_C) begin
          rpt_d  = '0;
          accept = 1'b1;
        end else begin
          rpt_d = sat_inc(rpt_q);
        end
`endif
      end
      RELEASE_WAIT: begin
        if (!btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_C) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are registered and default low, so each acceptance yields one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      rejected <= 1'b0;
      wr_data  <= '0;
    end else begin
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      rejected <= 1'b0;
      if (accept) begin
        if (mode_s) begin
          if (!full) begin
            wr_en   <= 1'b1;
            wr_data <= datain;
          end else begin
            rejected <= 1'b1;
          end
        end else begin
          if (!empty) rd_en    <= 1'b1;
          else        rejected <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_cmd_conditioner.sv
// Directed self-checking bench for fifo_cmd_conditioner (DEBOUNCE_CYCLES = 4).
module tb_fifo_cmd_conditioner;
  import fifo_ctrl_pkg::*;

  localparam int DW = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          button = 1'b1;
  logic          mode = 1'b0;
  logic [DW-1:0] datain = '0;
  logic          full = 1'b0;
  logic          empty = 1'b1;
  logic          wr_en, rd_en, rejected;
  logic [DW-1:0] wr_data;

  int tests = 0;
  int fails = 0;
  int n_wr = 0, n_rd = 0, n_rej = 0;
  int w0, r0, j0;

  fifo_cmd_conditioner #(
    .DATA_W(DW), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .button(button), .mode(mode),
    .datain(datain), .full(full), .empty(empty),
    .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data), .rejected(rejected)
  );

  always #5 clk = ~clk;

  // Count high cycles of each strobe.
  always @(posedge clk) begin
    if (wr_en)    n_wr  <= n_wr + 1;
    if (rd_en)    n_rd  <= n_rd + 1;
    if (rejected) n_rej <= n_rej + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    w0 = n_wr; r0 = n_rd; j0 = n_rej;
  endtask

  task automatic check_counts(input string tag, input int ew, input int er, input int ej);
    check({tag, "_wr_cnt"},  32'(n_wr - w0),  32'(ew));
    check({tag, "_rd_cnt"},  32'(n_rd - r0),  32'(er));
    check({tag, "_rej_cnt"}, 32'(n_rej - j0), 32'(ej));
  endtask

  task automatic press(input int low, input int rel);
    button = 1'b0;
    step(low);
    button = 1'b1;
    step(rel);
  endtask

  initial begin
    // Reset state
    step(3);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_rejected", 32'(rejected), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    reset_n = 1'b1;
    step(3);

    // Clean write: strobe exactly in the cycle after edge 7
    mode = 1'b1; datain = 15'd32000; empty = 1'b1; full = 1'b0;
    step(4);
    snap();
    button = 1'b0;
    step(6);
    check("cw_wr_before", 32'(wr_en), 0);
    step(1);
    check("cw_wr_edge7", 32'(wr_en), 1);
    check("cw_wr_data", 32'(wr_data), 32000);
    check("cw_rd_edge7", 32'(rd_en), 0);
    step(1);
    check("cw_wr_after", 32'(wr_en), 0);
    step(12);
    button = 1'b1;
    step(12);
    check_counts("cw", 1, 0, 0);

    // Bounce rejection
    snap();
    button = 1'b0; step(3);
    button = 1'b1; step(1);
    button = 1'b0; step(3);
    button = 1'b1; step(12);
    check_counts("bounce", 0, 0, 0);
    check("bounce_state", 32'(dut.state_q), 32'(IDLE));

    // Read while empty
    mode = 1'b0; empty = 1'b1;
    step(4);
    snap();
    button = 1'b0;
    step(7);
    check("rde_rej_edge7", 32'(rejected), 1);
    check("rde_rd_edge7", 32'(rd_en), 0);
    step(5);
    button = 1'b1;
    step(12);
    check_counts("rde", 0, 0, 1);
    check("rde_wr_data", 32'(wr_data), 32000);

    // Read with release bounce
    empty = 1'b0;
    step(2);
    snap();
    button = 1'b0;
    step(7);
    check("rd_rd_edge7", 32'(rd_en), 1);
    step(5);
    button = 1'b1; step(2);
    button = 1'b0; step(1);
    button = 1'b1; step(10);
    step(4);
    check_counts("rd", 0, 1, 0);
    check("rd_state", 32'(dut.state_q), 32'(IDLE));

    // Write 10250, then write while full
    mode = 1'b1; full = 1'b0; datain = 15'd10250;
    step(4);
    press(12, 12);
    check("w2_wr_data", 32'(wr_data), 10250);
    full = 1'b1; datain = 15'd100;
    step(2);
    snap();
    press(12, 12);
    check_counts("wfull", 0, 0, 1);
    check("wfull_wr_data", 32'(wr_data), 10250);
    full = 1'b0;

    // Reset in PRESS_WAIT, release with button still low
    datain = 15'd555;
    step(2);
    snap();
    button = 1'b0;
    step(4);
    check("rmp_state_pw", 32'(dut.state_q), 32'(PRESS_WAIT));
    reset_n = 1'b0;
    #1;
    check("rmp_rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rmp_rst_wr_data", 32'(wr_data), 0);
    step(3);
    check("rmp_rst_wr_en", 32'(wr_en), 0);
    check("rmp_rst_rejected", 32'(rejected), 0);
    reset_n = 1'b1;
    step(6);
    check("rmp_wr_before", 32'(wr_en), 0);
    step(1);
    check("rmp_wr_edge7", 32'(wr_en), 1);
    check("rmp_wr_data", 32'(wr_data), 555);
    step(13);
    button = 1'b1;
    step(12);
    check_counts("rmp", 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
